// File: rtl/fp32_sub_if.sv
// fp32_sub_if: operand/result handshake bundle for fp32_sub.
//   io_in_valid/io_in_ready   operand pair handshake (io_fpnumA - io_fpnumB)
//   io_out_valid/io_out_ready result handshake carrying io_fpDiff
interface fp32_sub_if;
    logic        io_in_valid;
    logic        io_in_ready;
    logic [31:0] io_fpnumA;
    logic [31:0] io_fpnumB;
    logic        io_out_valid;
    logic        io_out_ready;
    logic [31:0] io_fpDiff;
    modport master (
        output io_in_valid, io_fpnumA, io_fpnumB, io_out_ready,
        input  io_in_ready, io_out_valid, io_fpDiff
    );
    modport slave (
        input  io_in_valid, io_fpnumA, io_fpnumB, io_out_ready,
        output io_in_ready, io_out_valid, io_fpDiff
    );
endinterface

// File: rtl/fp32_sub.sv
// fp32_sub: multi-cycle IEEE-754 single subtractor (A - B), truncating, denormals flushed.
//   clock  rising-edge clock
//   reset  synchronous active-high reset
//   io     fp32_sub_if.slave: operands in on in_valid/in_ready, io_fpDiff out on out_valid/out_ready
module fp32_sub (
    input  logic       clock,
    input  logic       reset,
    fp32_sub_if.slave  io
);
    typedef enum logic [2:0] {IDLE, ALIGN, SUB, NORM, PACK, DONE} state_t;
    state_t             state_q, state_d;
    logic [31:0]        a_q, a_d, b_q, b_d, diff_q, diff_d;
    logic               sign_q, sign_d, eff_sub_q, eff_sub_d, nan_q, nan_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [23:0]        mx_q, mx_d, my_q, my_d;
    logic [24:0]        mant_q, mant_d;
    logic [7:0]         ea, eb, sh;
    logic [23:0]        ma, mb;
    logic               sb_eff, a_big;
    // Zero exponent flushes the operand to zero, so no hidden one.
    assign ea     = a_q[30:23];
    assign eb     = b_q[30:23];
    assign ma     = ea == 8'd0 ? 24'd0 : {1'b1, a_q[22:0]};
    assign mb     = eb == 8'd0 ? 24'd0 : {1'b1, b_q[22:0]};
    assign sb_eff = ~b_q[31];
    assign a_big  = {ea, ma} >= {eb, mb};
    assign sh     = a_big ? ea - eb : eb - ea;
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sign_d    = sign_q;
        eff_sub_d = eff_sub_q;
        nan_d     = nan_q;
        exp_d     = exp_q;
        mx_d      = mx_q;
        my_d      = my_q;
        mant_d    = mant_q;
        diff_d    = diff_q;
        unique case (state_q)
            IDLE: if (io.io_in_valid) begin
                a_d     = io.io_fpnumA;
                b_d     = io.io_fpnumB;
                state_d = ALIGN;
            end
            ALIGN: begin
                sign_d    = a_big ? a_q[31] : sb_eff;
                exp_d     = {2'b00, a_big ? ea : eb};
                mx_d      = a_big ? ma : mb;
                my_d      = sh >= 8'd24 ? 24'd0 : (a_big ? mb : ma) >> sh;
                // Equal raw signs mean the effective operation is a subtraction.
                eff_sub_d = a_q[31] == b_q[31];
                nan_d     = (&ea) || (&eb);
                state_d   = SUB;
            end
            SUB: begin
                mant_d  = eff_sub_q ? {1'b0, mx_q} - {1'b0, my_q} : {1'b0, mx_q} + {1'b0, my_q};
                state_d = NORM;
            end
            NORM: begin
                // Exponent out of range ends normalisation; PACK turns it into zero or infinity.
                if (nan_q || exp_q >= 10'sd255 || exp_q <= 10'sd0) state_d = PACK;
                else if (mant_q[24]) begin
                    mant_d = mant_q >> 1;
                    exp_d  = exp_q + 10'sd1;
                end else if (!mant_q[23] && |mant_q) begin
                    mant_d = mant_q << 1;
                    exp_d  = exp_q - 10'sd1;
                end else state_d = PACK;
            end
            PACK: begin
                diff_d  = nan_q ? 32'h7FC00000 :
                          (mant_q == 25'd0 || exp_q <= 10'sd0) ? 32'h0 :
                          exp_q >= 10'sd255 ? {sign_q, 8'hFF, 23'd0} :
                          {sign_q, exp_q[7:0], mant_q[22:0]};
                state_d = DONE;
            end
            DONE: if (io.io_out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sign_q    <= 1'b0;
            eff_sub_q <= 1'b0;
            nan_q     <= 1'b0;
            exp_q     <= '0;
            mx_q      <= '0;
            my_q      <= '0;
            mant_q    <= '0;
            diff_q    <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sign_q    <= sign_d;
            eff_sub_q <= eff_sub_d;
            nan_q     <= nan_d;
            exp_q     <= exp_d;
            mx_q      <= mx_d;
            my_q      <= my_d;
            mant_q    <= mant_d;
            diff_q    <= diff_d;
        end
    end
    assign io.io_in_ready  = state_q == IDLE;
    assign io.io_out_valid = state_q == DONE;
    assign io.io_fpDiff    = diff_q;
endmodule

// File: tb/tb_fp32_sub.sv
// tb_fp32_sub: scoreboard bench for fp32_sub with directed and random operands.
module tb_fp32_sub;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic auto_rdy = 1'b0, man_rdy = 1'b1, rnd_rdy = 1'b0;
    int   cyc = 0, checks = 0, errors = 0;
    typedef struct {logic [31:0] res; int lat; int acc;} exp_t;
    exp_t q[$];
    fp32_sub_if io();
    fp32_sub dut (.clock(clk), .reset(rst), .io(io));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign io.io_out_ready = auto_rdy ? rnd_rdy : man_rdy;
    initial forever begin
        @(negedge clk);
        rnd_rdy = 1'($urandom_range(0, 1));
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    // Reference: real-number rules of the block (truncating align, truncating normalise).
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output int s);
        longint ea, eb, ma, mb, ex, ey, mx, my, m, p, k, d;
        bit sa, sb, sx, sy;
        ea = longint'(a[30:23]);
        eb = longint'(b[30:23]);
        ma = ea == 0 ? 0 : (64'd1 << 23) + longint'(a[22:0]);
        mb = eb == 0 ? 0 : (64'd1 << 23) + longint'(b[22:0]);
        sa = a[31];
        sb = !b[31];
        s  = 0;
        if (ea == 255 || eb == 255) begin r = 32'h7FC00000; return; end
        if (ea * (64'd1 << 24) + ma >= eb * (64'd1 << 24) + mb) begin
            ex = ea; mx = ma; sx = sa; ey = eb; my = mb; sy = sb;
        end else begin
            ex = eb; mx = mb; sx = sb; ey = ea; my = ma; sy = sa;
        end
        d  = ex - ey;
        my = d >= 24 ? 0 : my >> d;
        m  = sx == sy ? mx + my : mx - my;
        if (m == 0) begin r = 32'h0; return; end
        p = $clog2(m + 1) - 1;
        if (p == 24) begin
            s = 1;
            r = ex + 1 >= 255 ? {sx, 8'hFF, 23'd0} : {sx, 8'(ex + 1), 23'(m >> 1)};
        end else begin
            k = 23 - p;
            if (ex - k <= 0) begin s = int'(ex); r = 32'h0; end
            else begin s = int'(k); r = {sx, 8'(ex - k), 23'(m << k)}; end
        end
    endfunction
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input int lat, input bit push);
        int n = 0;
        @(negedge clk);
        io.io_in_valid = 1'b1;
        io.io_fpnumA   = a;
        io.io_fpnumB   = b;
        while (!io.io_in_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("accept_timeout", 32'(io.io_in_ready), 32'd1);
        else if (push) q.push_back('{r, lat, cyc + 1});
        @(negedge clk);
        io.io_in_valid = 1'b0;
    endtask
    task automatic issue_model(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        int s;
        model(a, b, r, s);
        issue(a, b, r, s + 5, 1'b1);
    endtask
    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 2000) begin @(negedge clk); n++; end
        if (q.size() > 0) chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask
    // Monitor: compares first DONE cycle against scoreboard, then checks hold/retain behaviour.
    initial begin
        logic prev_v = 1'b0;
        logic [31:0] held = 32'h0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && io.io_out_valid) begin
                if (io.io_in_ready) chk("ready_in_done", 32'(io.io_in_ready), 32'd0);
                if (!prev_v) begin
                    if (q.size() == 0) chk("unexpected_valid", 32'(io.io_out_valid), 32'd0);
                    else begin
                        e = q.pop_front();
                        chk("result", io.io_fpDiff, e.res);
                        chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                    end
                    held = io.io_fpDiff;
                end else if (io.io_fpDiff !== held) chk("done_stable", io.io_fpDiff, held);
            end else if (!rst && prev_v && io.io_fpDiff !== held) chk("retain", io.io_fpDiff, held);
            prev_v = rst ? 1'b0 : io.io_out_valid;
        end
    end
    logic [31:0] vec [7][4] = '{
        '{32'h40400000, 32'h3F800000, 32'h40000000, 32'd5},
        '{32'h3F800000, 32'h40000000, 32'hBF800000, 32'd6},
        '{32'h3F800000, 32'hBF800000, 32'h40000000, 32'd6},
        '{32'h3F800000, 32'h3F800000, 32'h00000000, 32'd5},
        '{32'h7F800000, 32'h3F800000, 32'h7FC00000, 32'd5},
        '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 32'd6},
        '{32'h00800000, 32'h00C00000, 32'h00000000, 32'd6}
    };
    initial begin
        logic [31:0] a, b;
        logic [7:0] e;
        int n;
        io.io_in_valid = 1'b0;
        io.io_fpnumA   = '0;
        io.io_fpnumB   = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_in_ready", 32'(io.io_in_ready), 32'd1);
        chk("reset_out_valid", 32'(io.io_out_valid), 32'd0);
        chk("reset_diff", io.io_fpDiff, 32'h0);
        foreach (vec[i]) issue(vec[i][0], vec[i][1], vec[i][2], int'(vec[i][3]), 1'b1);
        drain();
        auto_rdy = 1'b1;
        for (int i = 0; i < 80; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: begin
                    e = a[30:23] + 8'($urandom_range(0, 4)) - 8'd2;
                    b = {1'($urandom), e, 23'($urandom)};
                end
                2: b = {1'($urandom), a[30:0] ^ 31'($urandom_range(0, 255))};
                default: begin
                    b = $urandom;
                    case ($urandom_range(0, 3))
                        0: a[30:23] = 8'h00;
                        1: a[30:23] = 8'hFF;
                        2: b[30:23] = 8'h00;
                        default: b[30:23] = 8'hFF;
                    endcase
                end
            endcase
            issue_model(a, b);
        end
        drain();
        auto_rdy = 1'b0;
        man_rdy  = 1'b1;
        // Reset during NORM: 1.0 - (1.0 - 2^-24) needs 23 left shifts.
        issue(32'h3F800000, 32'h3F7FFFFF, 32'h0, 0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midop_reset_in_ready", 32'(io.io_in_ready), 32'd1);
        chk("midop_reset_out_valid", 32'(io.io_out_valid), 32'd0);
        chk("midop_reset_diff", io.io_fpDiff, 32'h0);
        repeat (40) @(negedge clk);
        // Back-pressure: hold result in DONE for 10 cycles.
        man_rdy = 1'b0;
        issue(32'h40400000, 32'h3F800000, 32'h40000000, 5, 1'b1);
        n = 0;
        while (!io.io_out_valid && n < 50) begin @(negedge clk); n++; end
        chk("hold_reached_done", 32'(io.io_out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(io.io_out_valid), 32'd1);
            chk("hold_in_ready", 32'(io.io_in_ready), 32'd0);
        end
        man_rdy = 1'b1;
        @(negedge clk);
        chk("release_out_valid", 32'(io.io_out_valid), 32'd0);
        chk("release_in_ready", 32'(io.io_in_ready), 32'd1);
        chk("release_retained", io.io_fpDiff, 32'h40000000);
        drain();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp32_sub.md
FP32_SUB -- requirements
Module: fp32_sub

Interface
REQ-001 clock  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high; sampled only on rising edge of clock.
REQ-003 io_in_valid  input  1  operand pair present on io_fpnumA/io_fpnumB.
REQ-004 io_in_ready  output  1  block accepts operands this cycle.
REQ-005 io_fpnumA  input  32  IEEE-754 single minuend.
REQ-006 io_fpnumB  input  32  IEEE-754 single subtrahend.
REQ-007 io_out_valid  output  1  io_fpDiff holds a completed result.
REQ-008 io_out_ready  input  1  consumer takes result this cycle.
REQ-009 io_fpDiff  output  32  registered result A - B, IEEE-754 single.

Function
REQ-010 The block SHALL be a multi-cycle FSM with states IDLE, ALIGN, SUB, NORM, PACK, DONE.
REQ-011 io_in_ready SHALL be 1 only in IDLE; io_out_valid SHALL be 1 only in DONE.
REQ-012 Accept = io_in_valid && io_in_ready at an edge; operands SHALL be latched, IDLE -> ALIGN.
REQ-013 Unpack: sign, 8-bit exponent, 24-bit mantissa with hidden 1; exponent 0 SHALL be treated as zero value (denormals flushed), mantissa 0.
REQ-014 B sign SHALL be inverted (effective addend) before alignment.
REQ-015 ALIGN (1 cycle): larger-magnitude operand (exponent, then mantissa compare) becomes X, other Y; Y mantissa shifted right by eX-eY, shift >= 24 gives 0; discarded bits truncated (no guard/round bits); result sign = X effective sign.
REQ-016 SUB (1 cycle): 25-bit result = mX + mY if effective signs equal, else mX - mY (never negative).
REQ-017 NORM: one action per cycle: bit24 set -> shift right 1, exp+1; else bit23 clear and value nonzero -> shift left 1, exp-1; else -> PACK. Number of shift cycles s ranges 0..23.
REQ-018 Latency SHALL be exactly s+5 cycles from accept edge to first cycle io_out_valid=1 (ALIGN, SUB, s+1 NORM cycles, PACK).
REQ-019 Rounding SHALL be round-toward-zero (truncation) everywhere.
REQ-020 Zero mantissa result SHALL produce 0x00000000 (+0), s=0.
REQ-021 Exponent reaching 0 during NORM (underflow) SHALL produce 0x00000000.
REQ-022 Exponent reaching >= 255 (overflow) SHALL produce {sign, 0xFF, 23'b0}.
REQ-023 Either operand with exponent 255 (Inf/NaN) SHALL produce 0x7FC00000, s=0, same latency.
REQ-024 Internal exponent register SHALL be at least 10 bits signed to detect underflow/overflow without wrap.
REQ-025 PACK SHALL load io_fpDiff = {sign, exp[7:0], mant[22:0]}, then DONE.
REQ-026 DONE SHALL hold io_out_valid and io_fpDiff stable until io_out_ready=1; on that edge -> IDLE.
REQ-027 No new operand SHALL be accepted in the DONE-exit cycle (no bypass); next accept earliest one cycle later.
REQ-028 io_fpDiff SHALL retain the last result after DONE until next PACK.
REQ-029 io_in_valid while busy SHALL be ignored; io_out_ready outside DONE SHALL be ignored.

Reset
REQ-030 reset=1 SHALL force IDLE, io_fpDiff=0, io_out_valid=0, io_in_ready=1 after the edge, from any state.
REQ-031 Reset mid-operation SHALL discard the in-flight result; no io_out_valid pulse follows.
REQ-032 reset has priority over accept and output handshake in the same cycle.

Verification
REQ-033 A=0x40400000 (3.0), B=0x3F800000 (1.0) -> io_fpDiff=0x40000000, io_out_valid 5 cycles after accept.
REQ-034 A=0x3F800000, B=0x40000000 -> 0xBF800000 after 6 cycles (one left shift); A=0x3F800000, B=0xBF800000 -> 0x40000000 after 6 cycles (carry right shift).
REQ-035 A=B=0x3F800000 -> 0x00000000 after 5 cycles; A=0x7F800000, B=0x3F800000 -> 0x7FC00000 after 5 cycles.
REQ-036 A=0x7F7FFFFF, B=0xFF7FFFFF -> 0x7F800000; A=0x00800000, B=0x00C00000 -> 0x00000000 (underflow).
REQ-037 Hold io_out_ready=0 for 10 cycles in DONE -> io_fpDiff stable, io_in_ready=0; release -> IDLE next cycle, io_fpDiff retained.
REQ-038 Assert reset during NORM -> next cycle IDLE, io_fpDiff=0, io_out_valid never asserted for that operation.
